ahb_loadable_mem: RTL
=====================

AHB_LOADABLE_MEM -- requirements
Module: ahb_loadable_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, byte-address width; depth = 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 Parameter AHB_WRITE, default 0, selects mode: 0 = ROM mode, AHB writes ignored; 1 = RAM mode, AHB writes honoured.
REQ-003 HCLK  in  1  single clock for bus, loader and memory.
REQ-004 resetHW  in  1  reset, asynchronous, active-high.
REQ-005 HSEL, HREADY  in  1 each  AHB-lite slave select and bus ready.
REQ-006 HADDR  in  32, HTRANS  in  2, HWRITE  in  1, HSIZE  in  3, HWDATA  in  32  AHB-lite request signals.
REQ-007 HRDATA  out  32, HREADYOUT  out  1, HRESP  out  1  AHB-lite response signals.
REQ-008 loadButton  in  1  requests the loader at reset release.
REQ-009 rxByte  in  8, newByte  in  1  received byte and its one-cycle strobe, from an external UART.
REQ-010 ROMload  out  1  loader active.
REQ-011 loadDone  out  1, loadError  out  1  loader outcome flags.
REQ-012 status  out  ADDR_WIDTH-2  words written so far.

Function
REQ-013 Loader FSM states: IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR.
REQ-014 In the first cycle after reset release, the FSM SHALL go to CNT_LO if loadButton=1, else to IDLE.
REQ-015 CNT_LO and CNT_HI each consume one byte, forming word count N little-endian (16 bits).
REQ-016 If N=0 or N>depth, CNT_HI SHALL go to ERROR.
REQ-017 DATA assembles 4 bytes little-endian per word and writes it at address status, then increments status.
REQ-018 After word N is written, DATA SHALL go to CHECK (macro defined) or DONE (macro undefined).
REQ-019 Bytes arriving in IDLE, DONE or ERROR SHALL be ignored; those three states are terminal until reset.
REQ-020 ROMload=1 in CNT_LO through CHECK; loadDone=1 in DONE only; loadError=1 in ERROR only.
REQ-021 Reads: an address phase (HSEL & HREADY & HTRANS[1] & !HWRITE) SHALL return the word at HADDR[ADDR_WIDTH-1:2] on HRDATA in the next cycle; HADDR bits above ADDR_WIDTH-1 are ignored (alias).
REQ-022 Writes (AHB_WRITE=1): address, HSIZE and byte lanes SHALL be registered in the address phase; the write SHALL commit in the data phase using HWDATA, enabling byte lanes per HSIZE (0/1/2) and HADDR[1:0].
REQ-023 Read-after-write hazard: a read whose address phase coincides with a write data phase to the same word SHALL see HREADYOUT=0 for exactly one cycle, then receive the merged new data.
REQ-024 While ROMload=1, HREADYOUT SHALL be 0 for any selected transfer, and AHB writes SHALL NOT reach the memory.
REQ-025 In ERROR, reads SHALL complete normally and return memory contents.
REQ-026 HRESP SHALL be constant 0; IDLE/BUSY transfers SHALL cause no access.

Reset
REQ-027 resetHW SHALL force: FSM to IDLE, status=0, ROMload=0, loadDone=0, loadError=0, HREADYOUT=1, pending-write and hazard registers cleared, byte assembler and checksum cleared.
REQ-028 Memory contents SHALL be preserved across reset; a reset mid-load SHALL abort the load, and words already written remain.

Configuration
REQ-029 Macro AHB_LOADABLE_MEM_CHECKSUM_EN: when defined, CHECK SHALL consume one byte and go to DONE if it equals the mod-256 sum of all 4N data bytes, else to ERROR.
REQ-030 When AHB_LOADABLE_MEM_CHECKSUM_EN is undefined, no checksum byte is expected, the CHECK state is not implemented, and the checksum logic is absent.

Verification
REQ-031 loadButton=1 at reset release, send bytes 02 00 11 22 33 44 55 66 77 88 (+checksum 0x64 if the macro is defined) -> words 0x44332211 at 0 and 0x88776655 at 1, status=2, loadDone=1, ROMload=0.
REQ-032 Count bytes FF FF with ADDR_WIDTH=15 -> loadError=1, ROMload=0, no memory write.
REQ-033 Macro defined, one word, wrong checksum -> loadError=1; word still readable at address 0.
REQ-034 AHB_WRITE=1: byte write 0xAB at 0x5, then immediate word read of 0x4 -> one-cycle HREADYOUT=0, then HRDATA=old word with byte1=0xAB.
REQ-035 AHB_WRITE=0: word write to 0x8 then read 0x8 -> original contents unchanged, HREADYOUT=1 throughout.
REQ-036 Assert resetHW after 3 data bytes of a load -> all flags 0, FSM IDLE, status=0, subsequent bytes ignored.

Source files
------------

// File: rtl/ahb_loadable_mem.sv
// AHB-lite word memory that a UART byte-stream loader fills after reset.
// Define AHB_LOADABLE_MEM_CHECKSUM_EN to require a trailing mod-256 checksum byte.
//
// state  | meaning
// IDLE   | no load requested, or reset just released (first_q decides)
// CNT_LO | waiting for word-count low byte
// CNT_HI | waiting for word-count high byte
// DATA   | assembling little-endian words and writing them at status
// CHECK  | waiting for checksum byte (checksum build only)
// DONE   | load finished, terminal until reset
// ERROR  | bad count or checksum, terminal until reset
module ahb_loadable_mem #(
    parameter int ADDR_WIDTH = 15,
    parameter int AHB_WRITE  = 0
) (
    input  logic                  HCLK,
    input  logic                  resetHW,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    input  logic                  loadButton,
    input  logic [7:0]            rxByte,
    input  logic                  newByte,
    output logic                  ROMload,
    output logic                  loadDone,
    output logic                  loadError,
    output logic [ADDR_WIDTH-3:0] status
);
    localparam int WW = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** WW;
    localparam logic [16:0] DEPTH_N = 17'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, CNT_LO, CNT_HI, DATA,
`ifdef AHB_LOADABLE_MEM_CHECKSUM_EN
        CHECK,
`endif
        DONE, ERROR
    } state_t;

    state_t          state_q, state_d;
    logic            first_q;
    logic [7:0]      cnt_lo_q;
    logic [15:0]     words_left_q;
    logic [1:0]      byte_idx_q;
    logic [23:0]     word_asm_q;
    logic [WW-1:0]   status_q;
    logic            load_we, load_wr_q;
    logic [15:0]     count_n;
    logic [31:0]     load_wdata;
`ifdef AHB_LOADABLE_MEM_CHECKSUM_EN
    logic [7:0]      cksum_q;
`endif

    assign count_n    = {rxByte, cnt_lo_q};
    assign load_wdata = {rxByte, word_asm_q};
    assign status     = status_q;

    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            state_q <= IDLE;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_we   = 1'b0;
        ROMload   = 1'b0;
        loadDone  = 1'b0;
        loadError = 1'b0;
        case (state_q)
            IDLE: if (first_q && loadButton) state_d = CNT_LO;
            CNT_LO: begin
                ROMload = 1'b1;
                if (newByte) state_d = CNT_HI;
            end
            CNT_HI: begin
                ROMload = 1'b1;
                if (newByte) begin
                    if (count_n == 16'd0 || {1'b0, count_n} > DEPTH_N) state_d = ERROR;
                    else state_d = DATA;
                end
            end
            DATA: begin
                ROMload = 1'b1;
                if (newByte && byte_idx_q == 2'd3) begin
                    load_we = 1'b1;
`ifdef AHB_LOADABLE_MEM_CHECKSUM_EN
                    if (words_left_q == 16'd1) state_d = CHECK;
`else
                    if (words_left_q == 16'd1) state_d = DONE;
`endif
                end
            end
`ifdef AHB_LOADABLE_MEM_CHECKSUM_EN
            CHECK: begin
                ROMload = 1'b1;
                if (newByte) state_d = (rxByte == cksum_q) ? DONE : ERROR;
            end
`endif
            DONE:    loadDone  = 1'b1;
            ERROR:   loadError = 1'b1;
            default: state_d   = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            cnt_lo_q     <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            word_asm_q   <= '0;
            status_q     <= '0;
            load_wr_q    <= 1'b0;
`ifdef AHB_LOADABLE_MEM_CHECKSUM_EN
            cksum_q      <= '0;
`endif
        end else begin
            load_wr_q <= load_we;
            if (newByte) begin
                case (state_q)
                    CNT_LO: cnt_lo_q <= rxByte;
                    CNT_HI: words_left_q <= count_n;
                    DATA: begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        word_asm_q <= {rxByte, word_asm_q[23:8]};
`ifdef AHB_LOADABLE_MEM_CHECKSUM_EN
                        cksum_q    <= cksum_q + rxByte;
`endif
                        if (load_we) begin
                            status_q     <= status_q + WW'(1);
                            words_left_q <= words_left_q - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // AHB side: one pending data phase, stalled while loading or on a same-word RAW hazard
    logic            accept, ahb_we;
    logic [WW-1:0]   haddr_word, rd_addr, dp_addr_q;
    logic [3:0]      lanes, dp_lanes_q;
    logic            dp_valid_q, dp_write_q, hazard_q;
    logic [31:0]     hrdata_q;
    logic [31:0]     mem [DEPTH];
    logic            unused_bits;

    assign unused_bits = &{1'b0, HADDR[31:ADDR_WIDTH], HTRANS[0]};
    assign haddr_word  = HADDR[ADDR_WIDTH-1:2];
    assign accept      = HSEL && HREADY && HTRANS[1];
    assign HREADYOUT   = !hazard_q && !(dp_valid_q && (ROMload || load_wr_q));
    assign ahb_we      = (AHB_WRITE != 0) && dp_valid_q && dp_write_q && HREADYOUT;
    assign rd_addr     = HREADY ? haddr_word : dp_addr_q;
    assign HRDATA      = hrdata_q;
    assign HRESP       = 1'b0;

    always_comb begin
        lanes = 4'b1111;
        case (HSIZE)
            3'd0:    lanes = 4'b0001 << HADDR[1:0];
            3'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_lanes_q <= '0;
            hazard_q   <= 1'b0;
        end else begin
            if (HREADY) begin
                dp_valid_q <= accept;
                dp_write_q <= HWRITE;
                dp_addr_q  <= haddr_word;
                dp_lanes_q <= lanes;
            end
            hazard_q <= accept && !HWRITE && ahb_we && (haddr_word == dp_addr_q);
        end
    end

    // Contents survive reset, so the array has no reset branch
    always_ff @(posedge HCLK) begin
        if (load_we) begin
            mem[status_q] <= load_wdata;
        end else if (ahb_we) begin
            for (int i = 0; i < 4; i++)
                if (dp_lanes_q[i]) mem[dp_addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
        hrdata_q <= mem[rd_addr];
    end
endmodule
